// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: memory op encoding, FSM states, default depth.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } dmem_state_t;

    localparam int unsigned DMEM_WORDS = 16384;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with one synchronous read port and one write port; contents are never reset.
module dmem_array #(
    parameter int unsigned WORDS = 16384,
    parameter int unsigned IDX_W = 14
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_data_i
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk_i) begin
        rd_data_o <= mem[rd_idx_i];
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: checks, reads, merges sub-word stores and extends loads.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DMEM_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  mem_op_t     req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

    dmem_state_t      state;
    mem_op_t          op_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      req_off;
    logic [31:0]      q_off;
    logic [31:0]      rd_word;
    logic [31:0]      load_data;
    logic [31:0]      merged;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             req_err;
    logic             accept;
    logic             wr_en;

    assign req_ready_o = (state == ST_IDLE);
    assign rsp_valid_o = (state == ST_RESP);
    assign accept      = req_valid_i && req_ready_o;
    assign req_off     = req_addr_i - BASE_ADDR;
    assign q_off       = addr_q - BASE_ADDR;
    // Reset in the WRITE cycle must drop the store, so the enable is gated here.
    assign wr_en       = (state == ST_WRITE) && !rst_i;

    always_comb begin
        req_err = 1'b0;
        unique case (req_op_i)
            OP_LH, OP_LHU, OP_SH: req_err = req_addr_i[0];
            OP_LW, OP_SW:         req_err = (req_addr_i[1:0] != 2'b00);
            default:              req_err = 1'b0;
        endcase
        if ((req_addr_i < BASE_ADDR) || ({1'b0, req_addr_i} >= END_ADDR)) begin
            req_err = 1'b1;
        end
    end

    dmem_array #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i     (clk_i),
        .rd_idx_i  (req_off[IDX_W+1:2]),
        .rd_data_o (rd_word),
        .wr_en_i   (wr_en),
        .wr_idx_i  (q_off[IDX_W+1:2]),
        .wr_data_i (wdata_q)
    );

    always_comb begin
        sel_byte  = 8'(rd_word >> {addr_q[1:0], 3'b000});
        sel_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        unique case (op_q)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {24'h0, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  load_data = {16'h0, sel_half};
            default: load_data = rd_word;
        endcase

        merged = rd_word;
        if (op_q == OP_SB) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (req_err) begin
                            rsp_rdata_o <= '0;
                            rsp_err_o   <= 1'b1;
                            state       <= ST_RESP;
                        end else if (req_op_i == OP_SW) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (op_q == OP_SB || op_q == OP_SH) begin
                        wdata_q <= merged;
                        state   <= ST_WRITE;
                    end else begin
                        rsp_rdata_o <= load_data;
                        rsp_err_o   <= 1'b0;
                        state       <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: data, error flags, latency, backpressure and reset-in-write.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    mem_op_t     req_op_i = OP_LW;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .MEM_WORDS (16384),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(mem_op_t op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic err, int lat);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Issue one request from IDLE, measure latency, check response, then complete the handshake.
    task automatic run_req(input string name, input vec_t v);
        int lat;
        check({name, ".ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i    = v.op;
        req_addr_i  = v.addr;
        req_wdata_i = v.wdata;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 8) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({name, ".lat"}, 32'(lat), 32'(v.exp_lat));
        check({name, ".rdata"}, rsp_rdata_o, v.exp_rdata);
        check({name, ".err"}, 32'(rsp_err_o), 32'(v.exp_err));
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] held_rdata;
        int          lat;

        vecs.push_back(mk(OP_SW,  32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(OP_LW,  32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2));
        vecs.push_back(mk(OP_SB,  32'h8000_0011, 32'h0000_00AA, 32'h0000_0000, 1'b0, 3));
        vecs.push_back(mk(OP_LW,  32'h8000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0, 2));
        vecs.push_back(mk(OP_LB,  32'h8000_0011, 32'h0,         32'hFFFF_FFAA, 1'b0, 2));
        vecs.push_back(mk(OP_LBU, 32'h8000_0011, 32'h0,         32'h0000_00AA, 1'b0, 2));
        vecs.push_back(mk(OP_SH,  32'h8000_0012, 32'h0000_1234, 32'h0000_0000, 1'b0, 3));
        vecs.push_back(mk(OP_LW,  32'h8000_0010, 32'h0,         32'h1234_AAEF, 1'b0, 2));
        vecs.push_back(mk(OP_LH,  32'h8000_0012, 32'h0,         32'h0000_1234, 1'b0, 2));
        vecs.push_back(mk(OP_LH,  32'h8000_0010, 32'h0,         32'hFFFF_AAEF, 1'b0, 2));
        vecs.push_back(mk(OP_LHU, 32'h8000_0010, 32'h0,         32'h0000_AAEF, 1'b0, 2));
        vecs.push_back(mk(OP_LB,  32'h8000_0013, 32'h0,         32'h0000_0012, 1'b0, 2));
        vecs.push_back(mk(OP_LW,  32'h8000_0002, 32'h0,         32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(OP_SH,  32'h8000_0011, 32'h0000_5555, 32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(OP_SW,  32'h7FFF_FFFC, 32'h1111_1111, 32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(OP_LW,  32'h8001_0000, 32'h0,         32'h0000_0000, 1'b1, 1));
        vecs.push_back(mk(OP_LW,  32'h8000_0010, 32'h0,         32'h1234_AAEF, 1'b0, 2));
        vecs.push_back(mk(OP_SW,  32'h8000_FFFC, 32'h0102_0304, 32'h0000_0000, 1'b0, 2));
        vecs.push_back(mk(OP_SB,  32'h8000_FFFF, 32'hFFFF_FF80, 32'h0000_0000, 1'b0, 3));
        vecs.push_back(mk(OP_LW,  32'h8000_FFFC, 32'h0,         32'h8002_0304, 1'b0, 2));
        vecs.push_back(mk(OP_LB,  32'h8000_FFFF, 32'h0,         32'hFFFF_FF80, 1'b0, 2));
        vecs.push_back(mk(OP_LH,  32'h8000_FFFE, 32'h0,         32'hFFFF_8002, 1'b0, 2));

        repeat (2) @(posedge clk_i);
        #1;
        check("rst.ready", 32'(req_ready_o), 32'd1);
        check("rst.valid", 32'(rsp_valid_o), 32'd0);
        check("rst.rdata", rsp_rdata_o, 32'h0);
        check("rst.err",   32'(rsp_err_o), 32'd0);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold the load response while a stray SW is presented.
        req_valid_i = 1'b1;
        req_op_i    = OP_LW;
        req_addr_i  = 32'h8000_0010;
        @(posedge clk_i); #1;
        req_op_i    = OP_SW;
        req_wdata_i = 32'h0000_0000;
        lat = 1;
        while (!rsp_valid_o && lat < 8) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("bp.lat", 32'(lat), 32'd2);
        check("bp.rdata", rsp_rdata_o, 32'h1234_AAEF);
        held_rdata = rsp_rdata_o;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("bp.valid%0d", c), 32'(rsp_valid_o), 32'd1);
            check($sformatf("bp.rdata%0d", c), rsp_rdata_o, held_rdata);
            check($sformatf("bp.err%0d", c),   32'(rsp_err_o), 32'd0);
            check($sformatf("bp.ready%0d", c), 32'(req_ready_o), 32'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check("bp.idle", 32'(req_ready_o), 32'd1);
        run_req("bp.after", mk(OP_LW, 32'h8000_0010, 32'h0, 32'h1234_AAEF, 1'b0, 2));

        // Reset in the WRITE cycle of an SB: accept, READ, WRITE, then reset.
        req_valid_i = 1'b1;
        req_op_i    = OP_SB;
        req_addr_i  = 32'h8000_0010;
        req_wdata_i = 32'h0000_0055;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rw.pre_rdata", rsp_rdata_o, 32'h1234_AAEF);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rw.valid", 32'(rsp_valid_o), 32'd0);
        check("rw.ready", 32'(req_ready_o), 32'd1);
        check("rw.rdata", rsp_rdata_o, 32'h0);
        check("rw.err",   32'(rsp_err_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("rw.novalid%0d", c), 32'(rsp_valid_o), 32'd0);
        end
        run_req("rw.after", mk(OP_LW, 32'h8000_0010, 32'h0, 32'h1234_AAEF, 1'b0, 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, giving the number of 32-bit words in the data memory.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1 bit: the core presents a memory request.
REQ-006 SHALL have port req_ready_o, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_op_i, input, 3 bits: operation, of type mem_op_t (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-008 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata_i, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port rsp_valid_o, output, 1 bit: a response is pending.
REQ-011 SHALL have port rsp_ready_i, input, 1 bit: the core accepts the response.
REQ-012 SHALL have port rsp_rdata_o, output, 32 bits: extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err_o, output, 1 bit: the access was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-015 SHALL drive req_ready_o=1 only in IDLE; a request is accepted on req_valid_i&req_ready_o, and op, addr and wdata are latched at acceptance.
REQ-016 SHALL ignore all req_* inputs outside IDLE.
REQ-017 SHALL flag an error on acceptance in these cases:
- LH, LHU or SH with addr[0]=1.
- LW or SW with addr[1:0]!=0.
- addr<BASE_ADDR, or addr>=BASE_ADDR+4*MEM_WORDS.
REQ-018 SHALL handle an error request as follows: IDLE->RESP, rsp_err_o=1, rsp_rdata_o=0, no memory write.
REQ-019 SHALL handle a valid load or SB/SH as IDLE->READ; the word at index (addr-BASE_ADDR)>>2 is read synchronously.
REQ-020 SHALL handle READ as follows: for a load, compute the result and go to RESP; for SB/SH, merge the store lanes into the read word and go to WRITE.
REQ-021 SHALL handle a valid SW as IDLE->WRITE directly, with no read.
REQ-022 SHALL in WRITE write exactly one word, then go to RESP with rsp_rdata_o=0 and rsp_err_o=0.
REQ-023 SHALL have latency, measured from the acceptance edge N to rsp_valid_o high:
- error: N+1.
- load and SW: N+2.
- SB/SH: N+3.
REQ-024 SHALL use little-endian lane selection:
- SB/LB/LBU select byte addr[1:0].
- SH/LH/LHU select halfword addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
REQ-025 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i=1; RESP->IDLE on the handshake.
REQ-026 SHALL accept the next request no earlier than the cycle after the response handshake, so at most one request is in flight.
REQ-027 SHALL perform no memory write in any state other than WRITE.

Reset
REQ-028 SHALL on rst_i=1 at a clock edge set state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-029 SHALL suppress the write if rst_i=1 in the WRITE cycle; the in-flight request is dropped with no response.
REQ-030 SHALL NOT reset or clear memory contents.

Structure
REQ-031 SHALL take mem_op_t from the shared package; the dmem state enum and the DMEM_WORDS constant SHALL be added to that package.
REQ-032 SHALL instantiate the storage as sub-module dmem_array: word-wide, 1 synchronous read port, 1 write port, no reset.
REQ-033 SHALL keep lane merge and load extension as combinational logic inside dmem_responder.

Verification
REQ-034 SHALL cover: SW 0x8000_0010 with 0xDEADBEEF, then LW 0x8000_0010 -> rdata 0xDEADBEEF, err 0, rsp_valid at N+2.
REQ-035 SHALL cover: then SB 0x8000_0011 with 0x0000_00AA -> LW returns 0xDEADAAEF; LB 0x8000_0011 -> 0xFFFFFFAA; LBU -> 0x000000AA.
REQ-036 SHALL cover: then SH 0x8000_0012 with 0x0000_1234 -> LW 0x8000_0010 returns 0x1234AAEF; LH 0x8000_0012 -> 0x00001234; SB response at N+3.
REQ-037 SHALL cover: LW 0x8000_0002, SH 0x8000_0011, SW 0x7FFF_FFFC, LW 0x8001_0000 -> each gives err=1, rdata 0, at N+1; a later LW 0x8000_0010 still returns 0x1234AAEF.
REQ-038 SHALL cover: hold rsp_ready_i=0 for 5 cycles during a load -> rsp_valid_o, rsp_rdata_o and rsp_err_o stay constant, req_ready_o=0, and new req_valid_i is ignored.
REQ-039 SHALL cover: assert rst_i during the WRITE cycle of SB 0x8000_0010 with 0x55 -> outputs take their reset values next cycle and a later LW 0x8000_0010 returns 0x1234AAEF, i.e. unchanged.
